// File: rtl/divisor_secuencial.sv
// divisor_secuencial: sequential restoring (shift-subtract) unsigned divider.
// It produces one quotient bit per SHIFT/SUB pair. DONE is a one-cycle pulse.
// Divide-by-zero is detected in LOAD and skips the iteration loop.
// Results and DIV0 hold until the next LOAD.
module divisor_secuencial #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic [WIDTH-1:0] Dividendo,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Cociente,
   output logic [WIDTH-1:0] Residuo,
   output logic             DONE,
   output logic             DIV0,
   output logic             BUSY
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_SUB,
      ST_END
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;       // partial remainder, one guard bit
   logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] b_q, b_d;       // captured divisor
   logic [CW-1:0]    cnt_q, cnt_d;   // remaining quotient bits
   logic [WIDTH-1:0] coc_q, coc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             div0_q, div0_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [WIDTH:0]   a_diff;

   // State and datapath registers, asynchronously cleared by active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         coc_q   <= '0;
         res_q   <= '0;
         div0_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         coc_q   <= coc_d;
         res_q   <= res_d;
         div0_q  <= div0_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and datapath update for the restoring division sequence
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      coc_d   = coc_q;
      res_d   = res_q;
      div0_d  = div0_q;
      a_diff  = a_q - {1'b0, b_q};

      case (state_q)
         ST_IDLE: begin
            if (init) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            a_d    = '0;
            q_d    = Dividendo;
            b_d    = Divisor;
            cnt_d  = CW'(WIDTH);
            div0_d = 1'b0;
            if (Divisor == '0) begin
               coc_d   = '1;
               res_d   = Dividendo;
               div0_d  = 1'b1;
               state_d = ST_END;
            end else begin
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
            state_d    = ST_SUB;
         end

         ST_SUB: begin
            if (a_q >= {1'b0, b_q}) begin
               a_d = a_diff;
               q_d = {q_q[WIDTH-1:1], 1'b1};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               // Results are registered on the edge that enters END, so they are
               // already visible in the END cycle alongside the DONE pulse.
               coc_d   = q_d;
               res_d   = a_d[WIDTH-1:0];
               state_d = ST_END;
            end else begin
               state_d = ST_SHIFT;
            end
         end

         ST_END: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status flags are registered from the next state so they clear with reset
   always_comb begin
      done_d = (state_d == ST_END);
      busy_d = (state_d != ST_IDLE);
   end

   assign Cociente = coc_q;
   assign Residuo  = res_q;
   assign DIV0     = div0_q;
   assign DONE     = done_q;
   assign BUSY     = busy_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: directed and swept checks of the sequential divider.
module tb_divisor_secuencial;

   logic        clk = 1'b0;
   logic        reset;
   logic        init;
   logic [15:0] Dividendo;
   logic [15:0] Divisor;
   logic [15:0] Cociente;
   logic [15:0] Residuo;
   logic        DONE;
   logic        DIV0;
   logic        BUSY;

   int checks   = 0;
   int failures = 0;

   divisor_secuencial #(.WIDTH(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .init     (init),
      .Dividendo(Dividendo),
      .Divisor  (Divisor),
      .Cociente (Cociente),
      .Residuo  (Residuo),
      .DONE     (DONE),
      .DIV0     (DIV0),
      .BUSY     (BUSY)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present operands with init high across one rising edge (edge 0); returns at the next falling edge.
   task automatic start(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      Dividendo = a;
      Divisor   = b;
      init      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      init = 1'b0;
   endtask

   // Count rising edges until DONE is seen at a falling edge; bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (!DONE && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      if (!DONE) check("timeout_done", 32'(DONE), 32'd1);
   endtask

   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eq, input logic [15:0] er,
                      input logic ed0, input int elat);
      int n;
      start(a, b);
      wait_done(n);
      check({tag, "_lat"},  32'(n),        32'(elat));
      check({tag, "_q"},    32'(Cociente), 32'(eq));
      check({tag, "_r"},    32'(Residuo),  32'(er));
      check({tag, "_div0"}, 32'(DIV0),     32'(ed0));
      check({tag, "_busy"}, 32'(BUSY),     32'd1);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done1"}, 32'(DONE), 32'd0);
   endtask

   initial begin
      int n;
      logic [15:0] ra, rb;

      reset     = 1'b0;
      init      = 1'b0;
      Dividendo = '0;
      Divisor   = '0;
      #12;
      check("rst_q",    32'(Cociente), 32'd0);
      check("rst_r",    32'(Residuo),  32'd0);
      check("rst_done", 32'(DONE),     32'd0);
      check("rst_div0", 32'(DIV0),     32'd0);
      check("rst_busy", 32'(BUSY),     32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run("d100_7",      16'd100,   16'd7,     16'd14,    16'd2,    1'b0, 33);
      run("d65535_1",    16'd65535, 16'd1,     16'd65535, 16'd0,    1'b0, 33);
      run("d0_5",        16'd0,     16'd5,     16'd0,     16'd0,    1'b0, 33);
      run("d5_9",        16'd5,     16'd9,     16'd0,     16'd5,    1'b0, 33);
      run("d65535_65535",16'd65535, 16'd65535, 16'd1,     16'd0,    1'b0, 33);
      run("d1234_0",     16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1, 1);

      // Abort mid-operation: outputs were FFFF/1234/DIV0=1 before this
      start(16'd100, 16'd7);
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort_q",    32'(Cociente), 32'd0);
      check("abort_r",    32'(Residuo),  32'd0);
      check("abort_div0", 32'(DIV0),     32'd0);
      check("abort_busy", 32'(BUSY),     32'd0);
      check("abort_done", 32'(DONE),     32'd0);
      @(negedge clk);
      reset = 1'b1;
      run("d200_3", 16'd200, 16'd3, 16'd66, 16'd2, 1'b0, 33);

      // Re-pulsed init and changed operands during a run are ignored
      start(16'd100, 16'd7);
      repeat (5) @(negedge clk);
      check("hold_q", 32'(Cociente), 32'd66);
      check("hold_r", 32'(Residuo),  32'd2);
      init      = 1'b1;
      Dividendo = 16'd1;
      Divisor   = 16'd1;
      @(negedge clk);
      init = 1'b0;
      wait_done(n);
      check("mid_lat", 32'(n),        32'd27);
      check("mid_q",   32'(Cociente), 32'd14);
      check("mid_r",   32'(Residuo),  32'd2);
      @(negedge clk);

      // init held high: back-to-back operations
      Dividendo = 16'd200;
      Divisor   = 16'd3;
      init      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wait_done(n);
      check("b2b1_lat", 32'(n),        32'd33);
      check("b2b1_q",   32'(Cociente), 32'd66);
      check("b2b1_r",   32'(Residuo),  32'd2);
      Dividendo = 16'd5;
      Divisor   = 16'd9;
      @(posedge clk);
      @(negedge clk);
      wait_done(n);
      check("b2b2_lat", 32'(n + 1),    32'd35);
      check("b2b2_q",   32'(Cociente), 32'd0);
      check("b2b2_r",   32'(Residuo),  32'd5);
      init = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("b2b_idle", 32'(BUSY), 32'd0);

      // Swept pairs against the arithmetic reference
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = 16'd0;
            1, 2:    rb = 16'($urandom_range(1, 15));
            default: rb = 16'($urandom);
         endcase
         if (rb == 16'd0)
            run("sweep_div0", ra, rb, 16'hFFFF, ra, 1'b1, 1);
         else
            run("sweep", ra, rb, ra / rb, ra % rb, 1'b0, 33);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
